// File: rtl/global_ts_sync_ctrl.sv
// global_ts_sync_ctrl: periodic global timestamp synchronisation controller.
// Every PERIOD enabled cycles a round starts. It requests timestamps from the
// participating ports and reduces the captured ones to a maximum, then
// publishes that maximum as global_ts with a one-cycle global_vld strobe.
// Optional build macro GTS_MONOTONIC_EN: the published value is never smaller
// than the previous global_ts.
module global_ts_sync_ctrl #(
    parameter int unsigned TS_W    = 53,
    parameter int unsigned PERIOD  = 16,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [3:0]      port_mask,
    input  logic            err_clr,
    input  logic [3:0]      ts_vld,
    input  logic [TS_W-1:0] ts0,
    input  logic [TS_W-1:0] ts1,
    input  logic [TS_W-1:0] ts2,
    input  logic [TS_W-1:0] ts3,
    output logic [3:0]      ts_req,
    output logic [TS_W-1:0] global_ts,
    output logic            global_vld,
    output logic            busy,
    output logic [3:0]      timeout_err,
    output logic            overrun
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] REDUCE  = 2'd2;
    localparam logic [1:0] PUBLISH = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   period_cnt_q, period_cnt_d;
    logic            wrap;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      captured_q, captured_d;
    logic [3:0]      ts_req_d, timeout_err_d;
    logic [CW-1:0]   coll_cnt_q, coll_cnt_d;
    logic [1:0]      slot_q, slot_d;
    logic [TS_W-1:0] ts_in [4];
    logic [TS_W-1:0] ts_cap_q [4];
    logic [TS_W-1:0] ts_cap_d [4];
    logic [TS_W-1:0] max_q, max_d, global_ts_d;
    logic            found_q, found_d, global_vld_d, overrun_d;

    assign busy = (state_q != IDLE);

    // Gather the per-port timestamp inputs into an indexable array
    always_comb begin
        ts_in[0] = ts0;
        ts_in[1] = ts1;
        ts_in[2] = ts2;
        ts_in[3] = ts3;
    end

    // Period counter, round FSM, capture, reduction and sticky error flags
    always_comb begin
        wrap         = enable && (period_cnt_q == PW'(PERIOD - 1));
        period_cnt_d = (!enable || wrap) ? '0 : period_cnt_q + 1'b1;

        state_d       = state_q;
        mask_d        = mask_q;
        captured_d    = captured_q;
        ts_req_d      = ts_req;
        coll_cnt_d    = coll_cnt_q;
        slot_d        = slot_q;
        ts_cap_d      = ts_cap_q;
        max_d         = max_q;
        found_d       = found_q;
        global_ts_d   = global_ts;
        global_vld_d  = 1'b0;
        // Clear first so a same-edge set below wins over err_clr
        timeout_err_d = err_clr ? 4'b0 : timeout_err;
        overrun_d     = err_clr ? 1'b0 : overrun;

        case (state_q)
            IDLE: begin
                if (wrap) begin
                    mask_d     = port_mask;
                    captured_d = '0;
                    coll_cnt_d = '0;
                    slot_d     = '0;
                    found_d    = 1'b0;
                    max_d      = '0;
                    // An empty mask is a null round: stay idle, publish nothing
                    if (port_mask != 4'b0) begin
                        state_d  = COLLECT;
                        ts_req_d = port_mask;
                    end
                end
            end
            COLLECT: begin
                for (int i = 0; i < 4; i++) begin
                    if (ts_req[i] && ts_vld[i]) begin
                        captured_d[i] = 1'b1;
                        ts_cap_d[i]   = ts_in[i];
                    end
                end
                if (captured_d == mask_q || coll_cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_d = timeout_err_d | (mask_q & ~captured_d);
                    ts_req_d      = '0;
                    state_d       = REDUCE;
                end else begin
                    ts_req_d   = mask_q & ~captured_d;
                    coll_cnt_d = coll_cnt_q + 1'b1;
                end
            end
            REDUCE: begin
                // One slot per cycle; uncaptured slots never contribute
                if (captured_q[slot_q] && (!found_q || ts_cap_q[slot_q] > max_q)) begin
                    max_d   = ts_cap_q[slot_q];
                    found_d = 1'b1;
                end
                slot_d = slot_q + 1'b1;
                if (slot_q == 2'd3) begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                if (found_q) begin
`ifdef GTS_MONOTONIC_EN
                    global_ts_d = (global_ts > max_q) ? global_ts : max_q;
`else
                    global_ts_d = max_q;
`endif
                    global_vld_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A period boundary that finds a round still running is an overrun
        if (wrap && state_q != IDLE) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            mask_q       <= '0;
            captured_q   <= '0;
            coll_cnt_q   <= '0;
            slot_q       <= '0;
            max_q        <= '0;
            found_q      <= 1'b0;
            ts_req       <= '0;
            global_ts    <= '0;
            global_vld   <= 1'b0;
            timeout_err  <= '0;
            overrun      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ts_cap_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            mask_q       <= mask_d;
            captured_q   <= captured_d;
            coll_cnt_q   <= coll_cnt_d;
            slot_q       <= slot_d;
            max_q        <= max_d;
            found_q      <= found_d;
            ts_req       <= ts_req_d;
            global_ts    <= global_ts_d;
            global_vld   <= global_vld_d;
            timeout_err  <= timeout_err_d;
            overrun      <= overrun_d;
            for (int i = 0; i < 4; i++) begin
                ts_cap_q[i] <= ts_cap_d[i];
            end
        end
    end

endmodule
